// File: rtl/tt3_sweep_capture.sv
// Exhaustive 3-input truth-table sweeper: drives all eight input codes into an
// attached logic block, samples its synchronised output and compares the code.
module tt3_sweep_capture #(
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    output logic [2:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The synchronised output must have caught up with dut_in before it is sampled.
    generate
        if (SETTLE < SYNC_STAGES + 1) begin : g_bad_settle
            $error("tt3_sweep_capture: SETTLE must be >= SYNC_STAGES+1");
        end
        if (SYNC_STAGES > 3) begin : g_bad_sync
            $error("tt3_sweep_capture: SYNC_STAGES must be 0..3");
        end
    endgenerate

    logic out_sync;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign out_sync = dut_out;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= SYNC_STAGES'({sync_q, dut_out});
                end
            end
            assign out_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [1:0]       state_q,  state_d;
    logic [2:0]       idx_q,    idx_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [7:0]       exp_q,    exp_d;
    logic [7:0]       table_q,  table_d;
    logic [2:0]       dut_in_q, dut_in_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             match_q,  match_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            table_q  <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            table_q  <= table_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            match_q  <= match_d;
        end
    end

    // Sweep sequencing; dut_in is loaded one cycle ahead so it tracks idx.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        table_d  = table_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        match_d  = match_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d    = expected;
                    table_d  = '0;
                    match_d  = 1'b0;
                    idx_d    = '0;
                    cnt_d    = '0;
                    dut_in_d = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    table_d[3'd7 - idx_q] = out_sync;
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        match_d  = (table_d == exp_q);
                        dut_in_d = '0;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        dut_in_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign match     = match_q;

endmodule
